// File: rtl/piso_serializer_if.sv
// Load handshake, shift control and serial/parallel outputs of the PISO serializer.
// The producer side drives load and shift controls; the serializer drives everything else.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             sdi;
  logic             sdo;
  logic             sdo_valid;
  logic             frame_start;
  logic             last;
  logic [WIDTH-1:0] q;

  modport master (
    output load_valid, load_data, shift_en, sdi,
    input  load_ready, sdo, sdo_valid, frame_start, last, q
  );

  modport slave (
    input  load_valid, load_data, shift_en, sdi,
    output load_ready, sdo, sdo_valid, frame_start, last, q
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with gapless reload on the final bit, shift stall,
// and capture of the bits arriving on sdi into the vacated end of the register.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  piso_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, shreg_shifted;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             load_ready;
  logic             accept;
  logic             final_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

  // The final-bit cycle is the only SHIFT cycle that may accept, which is what keeps frames gapless.
  always_comb begin
    final_bit     = (state == SHIFT) && (cnt == CNT_LAST);
    load_ready    = (state == IDLE) || (final_bit && bus.shift_en);
    accept        = bus.load_valid && load_ready;
    shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], bus.sdi} : {bus.sdi, shreg[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nx = bus.load_data;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (!final_bit) begin
            shreg_nx = shreg_shifted;
            cnt_nx   = cnt + CW'(1);
          end else if (accept) begin
            shreg_nx = bus.load_data;
            cnt_nx   = '0;
          end else begin
            shreg_nx = shreg_shifted;
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.load_ready  = load_ready;
  assign bus.sdo_valid   = (state == SHIFT);
  assign bus.sdo         = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
  assign bus.frame_start = (state == SHIFT) && (cnt == '0);
  assign bus.last        = final_bit;
  assign bus.q           = shreg;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one stimulus stream and are
// compared against a frame-level model of bit order, handshake timing and sdi capture.
module tb_piso_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic         lv = 1'b0;
  logic [W-1:0] ld = '0;
  logic         se = 1'b0;
  logic         sd = 1'b0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus0 ();
  piso_serializer_if #(.WIDTH(W)) bus1 ();

  assign bus0.load_valid = lv;
  assign bus0.load_data  = ld;
  assign bus0.shift_en   = se;
  assign bus0.sdi        = sd;
  assign bus1.load_valid = lv;
  assign bus1.load_data  = ld;
  assign bus1.shift_en   = se;
  assign bus1.sdi        = sd;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset_n(reset_n), .bus(bus0));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset_n(reset_n), .bus(bus1));

  logic [1:0]   vld_s, sdo_s, fs_s, last_s, rdy_s;
  logic [W-1:0] q_s [2];
  assign vld_s  = {bus1.sdo_valid, bus0.sdo_valid};
  assign sdo_s  = {bus1.sdo, bus0.sdo};
  assign fs_s   = {bus1.frame_start, bus0.frame_start};
  assign last_s = {bus1.last, bus0.last};
  assign rdy_s  = {bus1.load_ready, bus0.load_ready};
  assign q_s[0] = bus0.q;
  assign q_s[1] = bus1.q;

  int tests = 0;
  int fails = 0;

  // Expected presented bits, packed {sdo, frame_start, last}, one entry per frame bit.
  logic [2:0] expq0[$];
  logic [2:0] expq1[$];

  // Frame model: bits still to be presented, and sdi bits captured in arrival order.
  int rem = 0;
  bit arr [W];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [2:0] got;
    logic [2:0] want;
    int         qsize;
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        got   = {sdo_s[d], fs_s[d], last_s[d]};
        qsize = (d == 0) ? expq0.size() : expq1.size();
        chk($sformatf("sdo_valid[%0d]", d), 32'(vld_s[d]), 32'(qsize > 0));
        if (vld_s[d] && qsize > 0) begin
          want = (d == 0) ? expq0[0] : expq1[0];
          chk($sformatf("sdo/start/last[%0d]", d), 32'(got), 32'(want));
          if (se) begin
            if (d == 0) void'(expq0.pop_front());
            else        void'(expq1.pop_front());
          end
        end else if (!vld_s[d]) begin
          chk($sformatf("idle_outputs[%0d]", d), 32'(got), 32'(0));
        end
      end
    end
  end

  task automatic push_frame(input logic [W-1:0] w);
    for (int k = 0; k < W; k++) begin
      expq0.push_back({w[W-1-k], k == 0, k == W-1});
      expq1.push_back({w[k],     k == 0, k == W-1});
    end
  endtask

  task automatic check_q();
    logic [W-1:0] em, el;
    for (int i = 0; i < W; i++) begin
      em[W-1-i] = arr[i];
      el[i]     = arr[i];
    end
    chk("q_msb_first", 32'(q_s[0]), 32'(em));
    chk("q_lsb_first", 32'(q_s[1]), 32'(el));
  endtask

  // One clock cycle: drive inputs just after an edge, check load_ready, advance the model.
  task automatic step(input bit lv_i, input logic [W-1:0] ld_i, input bit se_i, input bit sd_i);
    bit ready, acc, ended;
    lv = lv_i; ld = ld_i; se = se_i; sd = sd_i;
    #1;
    ready = (rem == 0) || (rem == 1 && se_i);
    chk("load_ready_msb", 32'(rdy_s[0]), 32'(ready));
    chk("load_ready_lsb", 32'(rdy_s[1]), 32'(ready));
    acc   = lv_i && ready;
    ended = 1'b0;
    if (rem > 0 && se_i) begin
      arr[W-rem] = sd_i;
      rem--;
      ended = (rem == 0);
    end
    if (acc) begin
      rem   = W;
      ended = 1'b0;
    end
    @(posedge clk);
    #1;
    if (acc)   push_frame(ld_i);
    if (ended) check_q();
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    rem = 0;
    expq0.delete();
    expq1.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid[%0d]", tag, d), 32'(vld_s[d]), 32'(0));
      chk($sformatf("%s_sdo[%0d]", tag, d),   32'(sdo_s[d]), 32'(0));
      chk($sformatf("%s_start[%0d]", tag, d), 32'(fs_s[d]),  32'(0));
      chk($sformatf("%s_last[%0d]", tag, d),  32'(last_s[d]), 32'(0));
      chk($sformatf("%s_q[%0d]", tag, d),     32'(q_s[d]),   32'(0));
      chk($sformatf("%s_ready[%0d]", tag, d), 32'(rdy_s[d]), 32'(1));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] stall_sdi;
    stall_sdi = 8'b1001_0110;
    assert_reset();

    // Reset held two cycles with random inputs.
    repeat (2) begin
      @(posedge clk);
      #1;
      lv = 1'($urandom); ld = W'($urandom); se = 1'($urandom); sd = 1'($urandom);
      #1;
      check_reset_outputs("reset");
    end
    lv = 1'b0;
    release_reset();
    repeat (3) step(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
    chk("q_after_release_msb", 32'(q_s[0]), 32'(0));
    chk("q_after_release_lsb", 32'(q_s[1]), 32'(0));

    // Single frame 0xC5 in both bit orders.
    step(1'b1, 8'hC5, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1, 1'($urandom));
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back 0xC5 then 0x3A, second word waiting through the first frame.
    step(1'b1, 8'hC5, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b1, 8'h3A, 1'b1, 1'($urandom));
    for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1, 1'($urandom));
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Stall after bit 3 with sdi capture of 1,0,0,1,0,1,1,0.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, stall_sdi[7-i]);
    repeat (3) step(1'b0, '0, 1'b0, 1'($urandom));
    for (int i = 3; i < W; i++) step(1'b0, '0, 1'b1, stall_sdi[7-i]);
    chk("stall_q_msb_96", 32'(q_s[0]), 32'h96);
    chk("stall_q_lsb_69", 32'(q_s[1]), 32'h69);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset during bit 4 of 0xC5, then a clean 0x3A frame.
    step(1'b1, 8'hC5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'($urandom));
    assert_reset();
    #1;
    check_reset_outputs("midreset");
    release_reset();
    step(1'b1, 8'h3A, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1, 1'($urandom));

    // Random traffic: bursty loads, random stalls and sdi.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 5) != 0, 1'($urandom));

    // Drain and confirm every expected bit was presented.
    for (int i = 0; i < 3 * W; i++) step(1'b0, '0, 1'b1, 1'($urandom));
    chk("drain_msb", 32'(expq0.size()), 32'(0));
    chk("drain_lsb", 32'(expq1.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with valid/ready load handshake, selectable bit order, shift stall, and concurrent serial-in capture. It is the successor to the fixed 4-bit preload/shift register. It sits between a word-oriented producer (register file, FIFO) and a 1-bit serial link. Frames go out gaplessly when the producer keeps up, and the bits shifted in on `sdi` are returned as a parallel word.

## Interface
- `WIDTH`, default 8: frame width in bits, must be >= 2. Counter width is `$clog2(WIDTH)`.
- `MSB_FIRST`, default 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  producer has a word on `load_data`.
- `load_ready`  out  1  block can accept a word this cycle.
- `load_data`  in  WIDTH  parallel word to serialize.
- `shift_en`  in  1  1 advances the frame by one bit; 0 stalls all state.
- `sdi`  in  1  serial input, shifted into the vacated end of the register.
- `sdo`  out  1  serial output bit; 0 when `sdo_valid`=0.
- `sdo_valid`  out  1  `sdo` carries a frame bit this cycle.
- `frame_start`  out  1  current `sdo` bit is bit 0 of a frame.
- `last`  out  1  current `sdo` bit is the final bit of a frame.
- `q`  out  WIDTH  shift register contents; holds the captured `sdi` word once a frame ends.

## Operation
- State machine: IDLE and SHIFT. Internal state: `shreg[WIDTH-1:0]` and bit counter `cnt`.
- `load_ready` = IDLE, or (SHIFT and `cnt`==WIDTH-1 and `shift_en`). It is combinational from state and `shift_en`.
- Accept occurs when `load_valid` and `load_ready` are both 1 on a rising edge. On accept: `shreg` <= `load_data`, `cnt` <= 0, state <= SHIFT.
- IDLE without accept: all state holds.
- SHIFT with `shift_en`=0: all state holds and outputs are unchanged, so the same bit stays presented.
- SHIFT with `shift_en`=1 and `cnt` < WIDTH-1: shift once and increment `cnt`.
  - MSB_FIRST=1: `shreg` <= {`shreg[WIDTH-2:0]`, `sdi`}.
  - MSB_FIRST=0: `shreg` <= {`sdi`, `shreg[WIDTH-1:1]`}.
- SHIFT with `shift_en`=1 and `cnt`==WIDTH-1 (final bit):
  - With accept: reload as above and stay in SHIFT. There is no gap between frames.
  - Without accept: perform the final shift, go to IDLE, `cnt` <= 0.
- `sdo` = `sdo_valid` ? (MSB_FIRST ? `shreg[WIDTH-1]` : `shreg[0]`) : 0.
- `sdo_valid` = SHIFT. `frame_start` = SHIFT and `cnt`==0. `last` = SHIFT and `cnt`==WIDTH-1.
- `q` = `shreg`. After a frame completes into IDLE, `q` holds the WIDTH `sdi` bits in arrival order:
  - MSB_FIRST=1: first-arrived bit at MSB.
  - MSB_FIRST=0: first-arrived bit at LSB.
- A final-bit reload discards the captured `sdi` word; the producer must sample `q` only after the return to IDLE.
- Asserting `load_valid` while `load_ready`=0 has no effect; the producer must hold the word until accepted.

## Timing
- Reset values: state IDLE, `shreg`=0, `cnt`=0. Outputs: `load_ready`=1, `sdo`=0, `sdo_valid`=0, `frame_start`=0, `last`=0, `q`=0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous) and discards its bits. The first rising edge after `reset_n` rises may accept a load.
- Latency: word accepted at edge T. Its first bit is on `sdo` from T until T+1. With no stalls, the last bit is presented from T+WIDTH-1 until T+WIDTH.
- Throughput: one frame per WIDTH enabled cycles. Each `shift_en`=0 cycle adds exactly one cycle.
- Back-to-back: `sdo_valid` stays 1 across the boundary; `last` in one cycle is followed by `frame_start` in the next.
- `load_data` and `sdi` are sampled only on rising edges; `sdi` is ignored in IDLE.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with random inputs -> all outputs at reset values and `load_ready`=1. Release -> no state change until `load_valid`.
- MSB-first, WIDTH=8: load 0xC5 with `shift_en`=1 -> `sdo` = 1,1,0,0,0,1,0,1 on 8 consecutive cycles. `frame_start` on the 1st bit, `last` on the 8th, then `sdo_valid`=0.
- LSB-first (MSB_FIRST=0): load 0xC5 -> `sdo` = 1,0,1,0,0,0,1,1.
- Back-to-back: 0xC5 then 0x3A, with `load_valid` held through the first frame's `last` cycle -> 16 contiguous valid bits 11000101 00111010. Second accept occurs exactly in the `last` cycle, with no idle cycle.
- Stall and capture: load 0xFF, drive `sdi` = 1,0,0,1,0,1,1,0, and drop `shift_en` for 3 cycles after bit 3 -> bit 3 is held for 4 cycles and the frame takes 11 cycles. `q`=0x96 in IDLE.
- Reset mid-frame: assert `reset_n`=0 during bit 4 of 0xC5 -> `sdo_valid` and `sdo` drop to 0 immediately and `q`=0. Next load of 0x3A serializes correctly from bit 0.
